// File: rtl/lsu.sv
// Load/store unit: runs one data-memory bus transaction per start pulse, aligns and
// extends load data, and reports misaligned, illegal-width and bus-timeout faults.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_result,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e          state_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic            load_q;
    logic [CntW-1:0] cnt_q;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] cnt_next;
    logic        timeout_hit;

    // Width legality and alignment are judged on the live inputs in the start cycle.
    always_comb begin
        illegal = 1'b0;
        if (is_load && is_store) begin
            illegal = 1'b1;
        end else if (is_load) begin
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else if (is_store) begin
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        wstrb_c = 4'b1111;
        wdata_c = store_data;
        unique case (funct3[1:0])
            2'b00: begin
                wstrb_c = 4'b0001 << addr[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (off_q)
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Counter reaches TIMEOUT-1 in the last wait cycle, giving exactly TIMEOUT request cycles.
    assign cnt_next    = 32'(cnt_q) + 32'd1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_next == TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            load_q      <= 1'b0;
            cnt_q       <= '0;
            load_result <= 32'h0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_wstrb   <= 4'b0000;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        funct3_q <= funct3;
                        off_q    <= addr[1:0];
                        load_q   <= is_load;
                        if (!is_load && !is_store) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else if (illegal) begin
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= 2'b10;
                            state_q     <= StDone;
                        end else if (misaligned) begin
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= 2'b01;
                            state_q     <= StDone;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_we    <= is_store;
                            mem_wstrb <= is_store ? wstrb_c : 4'b0000;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= wdata_c;
                            cnt_q     <= '0;
                            state_q   <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        done      <= 1'b1;
                        if (load_q) begin
                            load_result <= load_data;
                        end
                        state_q <= StDone;
                    end else if (timeout_hit) begin
                        mem_valid   <= 1'b0;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        fault_cause <= 2'b11;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    done        <= 1'b0;
                    fault       <= 1'b0;
                    fault_cause <= 2'b00;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected completions are queued at start and popped on done.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_result;
    logic        done;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] result;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          total = 0;
    logic [31:0] exp_lr = 32'h0;

    lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .load_result(load_result),
        .done(done), .fault(fault), .fault_cause(fault_cause), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        @(negedge clk);
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        start      = 1'b1;
    endtask

    // Acts as the bus slave; ready_on = n asserts mem_ready in the nth request cycle (0 = never).
    task automatic wait_done(input int ready_on, output int lat, output int nvalid,
                             output logic [31:0] a, output logic we, output logic [3:0] strb,
                             output logic [31:0] wd, output bit stable);
        lat = -1; nvalid = 0; stable = 1'b1; a = '0; we = 1'b0; strb = '0; wd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    a = mem_addr; we = mem_we; strb = mem_wstrb; wd = mem_wdata;
                end else if (a !== mem_addr || we !== mem_we || strb !== mem_wstrb ||
                             wd !== mem_wdata) begin
                    stable = 1'b0;
                end
                mem_ready = (ready_on != 0) && (nvalid == ready_on);
            end else begin
                mem_ready = 1'b0;
            end
            if (done) begin
                if (mem_valid) stable = 1'b0;
                lat = k;
                break;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        total++;
        if ({load_result, done, fault, fault_cause, mem_valid, mem_we, mem_wstrb} !== '0)
            $display("FAIL reset_ctrl got lr=%h done=%b fault=%b cause=%b valid=%b we=%b strb=%b want all 0",
                     load_result, done, fault, fault_cause, mem_valid, mem_we, mem_wstrb);
        else pass_cnt++;
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            $display("FAIL reset_bus got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        else pass_cnt++;
    endtask

    task automatic test_lw;
        int lat, nv; logic [31:0] a, wd; logic we; logic [3:0] st; bit stb; exp_t e;
        mem_rdata = 32'hDEADBEEF;
        sb.push_back('{1'b0, 2'b00, 32'hDEADBEEF});
        exp_lr = 32'hDEADBEEF;
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        wait_done(1, lat, nv, a, we, st, wd, stb);
        e = sb.pop_front();
        total++;
        if (lat !== 2 || a !== 32'h100 || we !== 1'b0 || st !== 4'b0000 || !stb)
            $display("FAIL lw_bus got lat=%0d addr=%h we=%b strb=%b stable=%0d want 2 100 0 0000 1",
                     lat, a, we, st, stb);
        else pass_cnt++;
        total++;
        if (fault !== e.fault || load_result !== e.result)
            $display("FAIL lw_result got fault=%b lr=%h want %b %h", fault, load_result,
                     e.fault, e.result);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL done_pulse got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3s[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
        logic [31:0] as[5]   = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] rds[5]  = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFFFF, 32'h1234F00F,
                                 32'h1234F00F};
        logic [31:0] exps[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000F00F,
                                 32'hFFFFF00F};
        for (int i = 0; i < 5; i++) begin
            int lat, nv; logic [31:0] a, wd; logic we; logic [3:0] st; bit stb; exp_t e;
            mem_rdata = rds[i];
            sb.push_back('{1'b0, 2'b00, exps[i]});
            exp_lr = exps[i];
            issue(1'b1, 1'b0, f3s[i], as[i], 32'h0);
            wait_done(2, lat, nv, a, we, st, wd, stb);
            e = sb.pop_front();
            total++;
            if (lat !== 3 || fault !== e.fault || load_result !== e.result)
                $display("FAIL load_ext[%0d] got lat=%0d fault=%b lr=%h want 3 %b %h", i, lat,
                         fault, load_result, e.fault, e.result);
            else pass_cnt++;
        end
    endtask

    task automatic test_store;
        logic [2:0]  f3s[3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] as[3]  = '{32'h206, 32'h201, 32'h208};
        logic [31:0] eas[3] = '{32'h204, 32'h200, 32'h208};
        logic [31:0] ewd[3] = '{32'hABCDABCD, 32'hCDCDCDCD, 32'h1234ABCD};
        logic [3:0]  est[3] = '{4'b1100, 4'b0010, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            int lat, nv; logic [31:0] a, wd; logic we; logic [3:0] st; bit stb; exp_t e;
            mem_rdata = 32'h55555555;
            sb.push_back('{1'b0, 2'b00, exp_lr});
            issue(1'b0, 1'b1, f3s[i], as[i], 32'h1234ABCD);
            wait_done(1, lat, nv, a, we, st, wd, stb);
            e = sb.pop_front();
            total++;
            if (lat !== 2 || a !== eas[i] || we !== 1'b1 || st !== est[i] || wd !== ewd[i] || !stb)
                $display("FAIL store_bus[%0d] got lat=%0d addr=%h we=%b strb=%b wdata=%h want 2 %h 1 %b %h",
                         i, lat, a, we, st, wd, eas[i], est[i], ewd[i]);
            else pass_cnt++;
            total++;
            if (fault !== e.fault || load_result !== e.result)
                $display("FAIL store_hold[%0d] got fault=%b lr=%h want %b %h", i, fault,
                         load_result, e.fault, e.result);
            else pass_cnt++;
        end
    endtask

    task automatic test_faults;
        logic        lds[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        sts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s[6] = '{3'b010, 3'b011, 3'b101, 3'b010, 3'b000, 3'b010};
        logic [31:0] as[6]  = '{32'h101, 32'h100, 32'h103, 32'h202, 32'h100, 32'h100};
        logic        efs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]  ecs[6] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 6; i++) begin
            int lat, nv; logic [31:0] a, wd; logic we; logic [3:0] st; bit stb; exp_t e;
            sb.push_back('{efs[i], ecs[i], exp_lr});
            issue(lds[i], sts[i], f3s[i], as[i], 32'hFFFFFFFF);
            wait_done(1, lat, nv, a, we, st, wd, stb);
            e = sb.pop_front();
            total++;
            if (lat !== 1 || nv !== 0 || fault !== e.fault || load_result !== e.result ||
                (e.fault && fault_cause !== e.cause))
                $display("FAIL fault[%0d] got lat=%0d valid_cycles=%0d fault=%b cause=%b lr=%h want 1 0 %b %b %h",
                         i, lat, nv, fault, fault_cause, load_result, e.fault, e.cause, e.result);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout;
        int lat, nv; logic [31:0] a, wd; logic we; logic [3:0] st; bit stb; exp_t e;
        sb.push_back('{1'b1, 2'b11, exp_lr});
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        wait_done(0, lat, nv, a, we, st, wd, stb);
        e = sb.pop_front();
        total++;
        if (nv !== 4 || lat !== 5 || fault !== e.fault || fault_cause !== e.cause ||
            load_result !== e.result)
            $display("FAIL timeout got valid_cycles=%0d lat=%0d fault=%b cause=%b lr=%h want 4 5 1 11 %h",
                     nv, lat, fault, fault_cause, load_result, e.result);
        else pass_cnt++;
        mem_rdata = 32'hCAFEF00D;
        sb.push_back('{1'b0, 2'b00, 32'hCAFEF00D});
        exp_lr = 32'hCAFEF00D;
        issue(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
        wait_done(3, lat, nv, a, we, st, wd, stb);
        e = sb.pop_front();
        total++;
        if (nv !== 3 || lat !== 4 || fault !== e.fault || load_result !== e.result || !stb)
            $display("FAIL wait_states got valid_cycles=%0d lat=%0d fault=%b lr=%h stable=%0d want 3 4 0 %h 1",
                     nv, lat, fault, load_result, stb, e.result);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int lat, nv; logic [31:0] a, wd; logic we; logic [3:0] st; bit stb; exp_t e;
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (mem_valid !== 1'b1) $display("FAIL rst_pre_valid got %b want 1", mem_valid);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        exp_lr = 32'h0;
        total++;
        if (mem_valid !== 1'b0 || done !== 1'b0 || load_result !== exp_lr)
            $display("FAIL rst_async got valid=%b done=%b lr=%h want 0 0 0", mem_valid, done,
                     load_result);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        mem_rdata = 32'h13572468;
        sb.push_back('{1'b0, 2'b00, 32'h13572468});
        exp_lr = 32'h13572468;
        issue(1'b1, 1'b0, 3'b010, 32'h404, 32'h0);
        wait_done(1, lat, nv, a, we, st, wd, stb);
        e = sb.pop_front();
        total++;
        if (lat !== 2 || a !== 32'h404 || fault !== e.fault || load_result !== e.result)
            $display("FAIL rst_recover got lat=%0d addr=%h fault=%b lr=%h want 2 404 0 %h", lat, a,
                     fault, load_result, e.result);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat, nv; logic [31:0] a, wd; logic we; logic [3:0] st; bit stb; exp_t e;
        mem_rdata = 32'h0000007F;
        sb.push_back('{1'b0, 2'b00, 32'h0000007F});
        exp_lr = 32'h0000007F;
        issue(1'b1, 1'b0, 3'b000, 32'h500, 32'h0);
        wait_done(1, lat, nv, a, we, st, wd, stb);
        e = sb.pop_front();
        total++;
        if (lat !== 2 || !stb || load_result !== e.result)
            $display("FAIL b2b_first got lat=%0d clean=%0d lr=%h want 2 1 %h", lat, stb,
                     load_result, e.result);
        else pass_cnt++;
        // start raised while done is high must be ignored
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h600; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (mem_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b_ignored got valid=%b done=%b want 0 0", mem_valid, done);
        else pass_cnt++;
        mem_rdata = 32'h87654321;
        sb.push_back('{1'b0, 2'b00, 32'h87654321});
        exp_lr = 32'h87654321;
        issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
        wait_done(1, lat, nv, a, we, st, wd, stb);
        e = sb.pop_front();
        total++;
        if (lat !== 2 || nv !== 1 || load_result !== e.result)
            $display("FAIL b2b_second got lat=%0d valid_cycles=%0d lr=%h want 2 1 %h", lat, nv,
                     load_result, e.result);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        test_lw;
        test_load_ext;
        test_store;
        test_faults;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
